// File: rtl/bram_asym_clr.sv
// Simple dual-port RAM with independent read/write widths, byte enables,
// a 1- or 2-stage read pipeline and a clear engine that zeroes the array.
module bram_asym_clr #(
   parameter int READ_WIDTH       = 64,
   parameter int READ_ADDR_WIDTH  = 9,
   parameter int WRITE_WIDTH      = 32,
   parameter int WRITE_ADDR_WIDTH = 10,
   parameter int BE_WIDTH         = 8,
   parameter int READ_LATENCY     = 1,
   parameter int RDW_MODE         = 0,
   parameter int CLEAR_ON_RESET   = 1
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                clear,
   output logic                                ready,
   input  logic                                w_valid,
   input  logic [WRITE_ADDR_WIDTH-1:0]         w_addr,
   input  logic [WRITE_WIDTH/BE_WIDTH-1:0]     w_be,
   input  logic [WRITE_WIDTH-1:0]              w_data,
   input  logic                                r_valid,
   input  logic [READ_ADDR_WIDTH-1:0]          r_addr,
   output logic [READ_WIDTH-1:0]               r_data,
   output logic                                r_data_valid
);

   localparam int MIN_W   = (READ_WIDTH < WRITE_WIDTH) ? READ_WIDTH : WRITE_WIDTH;
   localparam int MAX_W   = (READ_WIDTH < WRITE_WIDTH) ? WRITE_WIDTH : READ_WIDTH;
   localparam int MAX_AW  = (READ_ADDR_WIDTH > WRITE_ADDR_WIDTH) ? READ_ADDR_WIDTH : WRITE_ADDR_WIDTH;
   localparam int DEPTH   = 1 << MAX_AW;
   localparam int RATIO   = MAX_W / MIN_W;
   localparam int R_WORDS = READ_WIDTH / MIN_W;
   localparam int W_WORDS = WRITE_WIDTH / MIN_W;
   localparam int LOG2_RW = $clog2(R_WORDS);
   localparam int LOG2_WW = $clog2(W_WORDS);
   localparam int LPW     = MIN_W / BE_WIDTH;

   if (READ_WIDTH * (2 ** READ_ADDR_WIDTH) != WRITE_WIDTH * (2 ** WRITE_ADDR_WIDTH)) begin : g_bad_size
      $fatal(1, "bram_asym_clr: read and write port capacities differ");
   end
   if ((MAX_W % MIN_W) != 0 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_ratio
      $fatal(1, "bram_asym_clr: width ratio is not a power of two");
   end
   if (READ_LATENCY < 1 || READ_LATENCY > 2) begin : g_bad_lat
      $fatal(1, "bram_asym_clr: READ_LATENCY must be 1 or 2");
   end
   if ((MIN_W % BE_WIDTH) != 0) begin : g_bad_be
      $fatal(1, "bram_asym_clr: BE_WIDTH must divide the narrow width");
   end

   typedef enum logic {ST_CLEAR, ST_READY} state_t;

   state_t                                state_q, state_d;
   logic [MAX_AW-1:0]                     cnt_q, cnt_d;
   logic                                  clr_we;
   logic                                  wr_en, r_fire;
   logic [W_WORDS-1:0][MAX_AW-1:0]        w_na;
   logic [R_WORDS-1:0][MAX_AW-1:0]        r_na;
   logic [READ_WIDTH-1:0]                 rd_word;
   logic [READ_LATENCY:1]                 vld_pipe_q, vld_pipe_d;
   logic [READ_LATENCY:1][READ_WIDTH-1:0] data_pipe_q, data_pipe_d;

   logic [MIN_W-1:0] mem [DEPTH];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      clr_we  = 1'b0;
      case (state_q)
         ST_CLEAR: begin
            clr_we = 1'b1;
            if (cnt_q == {MAX_AW{1'b1}}) begin
               state_d = ST_READY;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + MAX_AW'(1);
            end
         end
         ST_READY: begin
            if (clear) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end
         end
         default: state_d = ST_READY;
      endcase
   end

   assign ready = (state_q == ST_READY);
   // the cycle a clear is taken still shows ready=1, but no access is accepted
   assign wr_en  = w_valid & ready & ~clear;
   assign r_fire = r_valid & ready & ~clear;

   always_comb begin
      for (int k = 0; k < W_WORDS; k++)
         w_na[k] = (MAX_AW'(w_addr) << LOG2_WW) | MAX_AW'(k);
      for (int k = 0; k < R_WORDS; k++)
         r_na[k] = (MAX_AW'(r_addr) << LOG2_RW) | MAX_AW'(k);
   end

   // Old contents come straight from the array; mode 1 overlays enabled write lanes.
   always_comb begin
      rd_word = '0;
      for (int k = 0; k < R_WORDS; k++) begin
         rd_word[k*MIN_W +: MIN_W] = mem[r_na[k]];
         if (RDW_MODE == 1) begin
            for (int j = 0; j < W_WORDS; j++)
               if (wr_en && (w_na[j] == r_na[k]))
                  for (int b = 0; b < LPW; b++)
                     if (w_be[j*LPW + b])
                        rd_word[k*MIN_W + b*BE_WIDTH +: BE_WIDTH] =
                           w_data[j*MIN_W + b*BE_WIDTH +: BE_WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[cnt_q] <= '0;
      end else if (wr_en) begin
         for (int k = 0; k < W_WORDS; k++)
            for (int b = 0; b < LPW; b++)
               if (w_be[k*LPW + b])
                  mem[w_na[k]][b*BE_WIDTH +: BE_WIDTH] <= w_data[k*MIN_W + b*BE_WIDTH +: BE_WIDTH];
      end
   end

   always_comb begin
      vld_pipe_d     = {vld_pipe_q[READ_LATENCY:1]};
      data_pipe_d    = data_pipe_q;
      vld_pipe_d[1]  = r_fire;
      if (r_fire) data_pipe_d[1] = rd_word;
      for (int s = 2; s <= READ_LATENCY; s++) begin
         vld_pipe_d[s] = vld_pipe_q[s-1];
         if (vld_pipe_q[s-1]) data_pipe_d[s] = data_pipe_q[s-1];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
         cnt_q       <= '0;
         vld_pipe_q  <= '0;
         data_pipe_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         vld_pipe_q  <= vld_pipe_d;
         data_pipe_q <= data_pipe_d;
      end
   end

   assign r_data       = data_pipe_q[READ_LATENCY];
   assign r_data_valid = vld_pipe_q[READ_LATENCY];

endmodule
